// File: rtl/axi_lite_sram.sv
// AXI-lite slave data memory with independent read/write FSMs and a programmable response latency.
// Optional macro SRAM_RAND_DELAY_EN: per-transaction latency taken from an 8-bit LFSR (1..16 cycles).
module axi_lite_sram #(
    parameter logic [31:0] ADDR_BASE   = 32'h8000_0000,
    parameter int          DEPTH_WORDS = 1024,
    parameter int          DELAY       = 1
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [31:0] awaddr,
    input  logic        awvalid,
    output logic        awready,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    input  logic        wvalid,
    output logic        wready,
    output logic [1:0]  bresp,
    output logic        bvalid,
    input  logic        bready,
    input  logic [31:0] araddr,
    input  logic        arvalid,
    output logic        arready,
    output logic [31:0] rdata,
    output logic [1:0]  rresp,
    output logic        rvalid,
    input  logic        rready
);

    localparam int          AW     = $clog2(DEPTH_WORDS);
    localparam logic [31:0] SPAN   = 32'(4 * DEPTH_WORDS);
    localparam logic [7:0]  DLY_M1 = 8'(DELAY - 1);

    typedef enum logic [1:0] {W_IDLE, W_WAIT, W_RESP} w_state_t;
    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} r_state_t;

    logic [31:0] r_mem [DEPTH_WORDS];

    w_state_t    r_wstate, w_wstate_nxt;
    r_state_t    r_rstate, w_rstate_nxt;
    logic        r_rdy_en;
    logic        r_aw_got, r_w_got;
    logic [31:0] r_awaddr, r_wdata, r_araddr;
    logic [3:0]  r_wstrb;
    logic [7:0]  r_wcnt, r_rcnt;
    logic        r_bvalid, r_rvalid;
    logic [1:0]  r_bresp, r_rresp;
    logic [31:0] r_rdata;

    logic [7:0]    w_dly_m1;
    logic          w_aw_hs, w_w_hs, w_aw_done, w_w_done, w_ar_hs;
    logic [31:0]   w_woff, w_roff;
    logic          w_win, w_rin, w_commit;
    logic [AW-1:0] w_widx, w_ridx;

`ifdef SRAM_RAND_DELAY_EN
    logic [7:0] r_lfsr;

    // Fibonacci LFSR, taps 8,6,5,4; free-running so each FSM sees its own sample.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_lfsr <= 8'h5A;
        else          r_lfsr <= {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
    end
    assign w_dly_m1 = {4'd0, r_lfsr[3:0]};
`else
    assign w_dly_m1 = DLY_M1;
`endif

    // Readies are held low through reset and rise on the first edge after release.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_rdy_en <= 1'b0;
        else          r_rdy_en <= 1'b1;
    end

    assign awready   = r_rdy_en && (r_wstate == W_IDLE) && !r_aw_got;
    assign wready    = r_rdy_en && (r_wstate == W_IDLE) && !r_w_got;
    assign arready   = r_rdy_en && (r_rstate == R_IDLE);
    assign w_aw_hs   = awvalid && awready;
    assign w_w_hs    = wvalid && wready;
    assign w_ar_hs   = arvalid && arready;
    assign w_aw_done = r_aw_got || w_aw_hs;
    assign w_w_done  = r_w_got || w_w_hs;

    // Offset wraps for addresses below the base, so one unsigned compare covers both bounds.
    assign w_woff   = r_awaddr - ADDR_BASE;
    assign w_roff   = r_araddr - ADDR_BASE;
    assign w_win    = w_woff < SPAN;
    assign w_rin    = w_roff < SPAN;
    assign w_widx   = AW'(w_woff >> 2);
    assign w_ridx   = AW'(w_roff >> 2);
    assign w_commit = (r_wstate == W_WAIT) && (r_wcnt == 8'd0) && w_win && i_rst_n;

    assign bvalid = r_bvalid;
    assign bresp  = r_bresp;
    assign rvalid = r_rvalid;
    assign rresp  = r_rresp;
    assign rdata  = r_rdata;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wstate <= W_IDLE;
            r_rstate <= R_IDLE;
        end else begin
            r_wstate <= w_wstate_nxt;
            r_rstate <= w_rstate_nxt;
        end
    end

    always_comb begin
        w_wstate_nxt = r_wstate;
        unique case (r_wstate)
            W_IDLE:  if (w_aw_done && w_w_done) w_wstate_nxt = W_WAIT;
            W_WAIT:  if (r_wcnt == 8'd0) w_wstate_nxt = W_RESP;
            W_RESP:  if (bready) w_wstate_nxt = W_IDLE;
            default: w_wstate_nxt = W_IDLE;
        endcase
    end

    always_comb begin
        w_rstate_nxt = r_rstate;
        unique case (r_rstate)
            R_IDLE:  if (w_ar_hs) w_rstate_nxt = R_WAIT;
            R_WAIT:  if (r_rcnt == 8'd0) w_rstate_nxt = R_RESP;
            R_RESP:  if (rready) w_rstate_nxt = R_IDLE;
            default: w_rstate_nxt = R_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_aw_got <= 1'b0;
            r_w_got  <= 1'b0;
            r_awaddr <= '0;
            r_wdata  <= '0;
            r_wstrb  <= '0;
            r_wcnt   <= '0;
            r_bvalid <= 1'b0;
            r_bresp  <= 2'b00;
        end else begin
            if (w_aw_hs) begin
                r_awaddr <= awaddr;
                r_aw_got <= 1'b1;
            end
            if (w_w_hs) begin
                r_wdata <= wdata;
                r_wstrb <= wstrb;
                r_w_got <= 1'b1;
            end
            unique case (r_wstate)
                W_IDLE: if (w_aw_done && w_w_done) begin
                    r_aw_got <= 1'b0;
                    r_w_got  <= 1'b0;
                    r_wcnt   <= w_dly_m1;
                end
                W_WAIT: if (r_wcnt != 8'd0) begin
                    r_wcnt <= r_wcnt - 8'd1;
                end else begin
                    r_bvalid <= 1'b1;
                    r_bresp  <= w_win ? 2'b00 : 2'b10;
                end
                W_RESP: if (bready) r_bvalid <= 1'b0;
                default: ;
            endcase
        end
    end

    // Array is never reset; only lanes with a set strobe are touched.
    always_ff @(posedge i_clk) begin
        if (w_commit) begin
            for (int i = 0; i < 4; i++) begin
                if (r_wstrb[i]) r_mem[w_widx][8*i +: 8] <= r_wdata[8*i +: 8];
            end
        end
    end

    // Reading the array here gives read-before-write against a same-edge commit.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_araddr <= '0;
            r_rcnt   <= '0;
            r_rvalid <= 1'b0;
            r_rresp  <= 2'b00;
            r_rdata  <= '0;
        end else begin
            unique case (r_rstate)
                R_IDLE: if (w_ar_hs) begin
                    r_araddr <= araddr;
                    r_rcnt   <= w_dly_m1;
                end
                R_WAIT: if (r_rcnt != 8'd0) begin
                    r_rcnt <= r_rcnt - 8'd1;
                end else begin
                    r_rvalid <= 1'b1;
                    r_rresp  <= w_rin ? 2'b00 : 2'b10;
                    r_rdata  <= w_rin ? r_mem[w_ridx] : 32'd0;
                end
                R_RESP: if (rready) r_rvalid <= 1'b0;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_lite_sram.sv
// Directed bench for axi_lite_sram: instance 0 runs DELAY=1, instance 1 runs DELAY=10.
module tb_axi_lite_sram;

    logic        clk = 1'b0;
    logic        rst_n   [2];
    logic [31:0] awaddr  [2];
    logic        awvalid [2];
    logic        awready [2];
    logic [31:0] wdata   [2];
    logic [3:0]  wstrb   [2];
    logic        wvalid  [2];
    logic        wready  [2];
    logic [1:0]  bresp   [2];
    logic        bvalid  [2];
    logic        bready  [2];
    logic [31:0] araddr  [2];
    logic        arvalid [2];
    logic        arready [2];
    logic [31:0] rdata   [2];
    logic [1:0]  rresp   [2];
    logic        rvalid  [2];
    logic        rready  [2];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    axi_lite_sram #(.DELAY(1)) u_dut0 (
        .i_clk(clk), .i_rst_n(rst_n[0]),
        .awaddr(awaddr[0]), .awvalid(awvalid[0]), .awready(awready[0]),
        .wdata(wdata[0]), .wstrb(wstrb[0]), .wvalid(wvalid[0]), .wready(wready[0]),
        .bresp(bresp[0]), .bvalid(bvalid[0]), .bready(bready[0]),
        .araddr(araddr[0]), .arvalid(arvalid[0]), .arready(arready[0]),
        .rdata(rdata[0]), .rresp(rresp[0]), .rvalid(rvalid[0]), .rready(rready[0])
    );

    axi_lite_sram #(.DELAY(10)) u_dut1 (
        .i_clk(clk), .i_rst_n(rst_n[1]),
        .awaddr(awaddr[1]), .awvalid(awvalid[1]), .awready(awready[1]),
        .wdata(wdata[1]), .wstrb(wstrb[1]), .wvalid(wvalid[1]), .wready(wready[1]),
        .bresp(bresp[1]), .bvalid(bvalid[1]), .bready(bready[1]),
        .araddr(araddr[1]), .arvalid(arvalid[1]), .arready(arready[1]),
        .rdata(rdata[1]), .rresp(rresp[1]), .rvalid(rvalid[1]), .rready(rready[1])
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input int u, input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] s, output logic [1:0] resp, output int lat);
        int k;
        awaddr[u] = a; wdata[u] = d; wstrb[u] = s;
        awvalid[u] = 1'b1; wvalid[u] = 1'b1;
        k = 0;
        while (!(awready[u] && wready[u]) && k < 300) begin tick(); k++; end
        tick();
        awvalid[u] = 1'b0; wvalid[u] = 1'b0;
        lat = 0;
        while (!bvalid[u] && lat < 300) begin tick(); lat++; end
        chk("wr_bvalid_seen", 32'(bvalid[u]), 32'd1);
        resp = bresp[u];
        bready[u] = 1'b1;
        tick();
        bready[u] = 1'b0;
        chk("wr_bvalid_clr", 32'(bvalid[u]), 32'd0);
    endtask

    task automatic do_read(input int u, input logic [31:0] a,
                           output logic [31:0] d, output logic [1:0] resp, output int lat);
        int k;
        araddr[u] = a; arvalid[u] = 1'b1;
        k = 0;
        while (!arready[u] && k < 300) begin tick(); k++; end
        tick();
        arvalid[u] = 1'b0;
        lat = 0;
        while (!rvalid[u] && lat < 300) begin tick(); lat++; end
        chk("rd_rvalid_seen", 32'(rvalid[u]), 32'd1);
        d = rdata[u]; resp = rresp[u];
        rready[u] = 1'b1;
        tick();
        rready[u] = 1'b0;
        chk("rd_rvalid_clr", 32'(rvalid[u]), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired before summary");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]  resp;
        logic [31:0] d;
        int          lat;

        for (int u = 0; u < 2; u++) begin
            rst_n[u] = 1'b0;
            awaddr[u] = '0; awvalid[u] = 1'b0; wdata[u] = '0; wstrb[u] = '0; wvalid[u] = 1'b0;
            bready[u] = 1'b0; araddr[u] = '0; arvalid[u] = 1'b0; rready[u] = 1'b0;
        end
        repeat (3) tick();

        chk("rst_awready", 32'(awready[0]), 32'd0);
        chk("rst_wready",  32'(wready[0]),  32'd0);
        chk("rst_arready", 32'(arready[0]), 32'd0);
        chk("rst_bvalid",  32'(bvalid[0]),  32'd0);
        chk("rst_rvalid",  32'(rvalid[0]),  32'd0);
        chk("rst_bresp",   32'(bresp[0]),   32'd0);
        chk("rst_rresp",   32'(rresp[0]),   32'd0);
        chk("rst_rdata",   rdata[0],        32'd0);

        rst_n[0] = 1'b1; rst_n[1] = 1'b1;
        #1;
        chk("rdy_before_edge", 32'(arready[0]), 32'd0);
        tick();
        chk("rdy_after_edge_ar", 32'(arready[0]), 32'd1);
        chk("rdy_after_edge_aw", 32'(awready[0]), 32'd1);
        chk("rdy_after_edge_w",  32'(wready[0]),  32'd1);

        // Full-word write and read-back at DELAY=1.
        do_write(0, 32'h8000_0010, 32'hDEAD_BEEF, 4'hF, resp, lat);
        chk("t1_bresp", 32'(resp), 32'd0);
        chk("t1_wlat", 32'(lat), 32'd1);
        do_read(0, 32'h8000_0010, d, resp, lat);
        chk("t1_rdata", d, 32'hDEAD_BEEF);
        chk("t1_rresp", 32'(resp), 32'd0);
        chk("t1_rlat", 32'(lat), 32'd1);

        // Byte-lane strobes, including an empty strobe.
        do_write(0, 32'h8000_0000, 32'h1122_3344, 4'hF, resp, lat);
        do_write(0, 32'h8000_0000, 32'hAABB_CCDD, 4'b0101, resp, lat);
        chk("t2_bresp", 32'(resp), 32'd0);
        do_read(0, 32'h8000_0000, d, resp, lat);
        chk("t2_rdata", d, 32'h11BB_33DD);
        do_write(0, 32'h8000_0000, 32'hFFFF_FFFF, 4'h0, resp, lat);
        chk("t2_strb0_bresp", 32'(resp), 32'd0);
        do_read(0, 32'h8000_0000, d, resp, lat);
        chk("t2_strb0_rdata", d, 32'h11BB_33DD);

        // AW at cycle 0, W at cycle 3.
        awaddr[0] = 32'h8000_0030; wdata[0] = 32'h5555_AAAA; wstrb[0] = 4'hF;
        awvalid[0] = 1'b1;
        tick();
        awvalid[0] = 1'b0;
        chk("t3_awready_low", 32'(awready[0]), 32'd0);
        chk("t3_wready_high", 32'(wready[0]), 32'd1);
        tick();
        chk("t3_no_bvalid_c2", 32'(bvalid[0]), 32'd0);
        tick();
        chk("t3_no_bvalid_c3", 32'(bvalid[0]), 32'd0);
        wvalid[0] = 1'b1;
        tick();
        wvalid[0] = 1'b0;
        chk("t3_bvalid_at_T", 32'(bvalid[0]), 32'd0);
        tick();
        chk("t3_bvalid_at_T1", 32'(bvalid[0]), 32'd1);
        chk("t3_bresp", 32'(bresp[0]), 32'd0);
        bready[0] = 1'b1;
        tick();
        bready[0] = 1'b0;
        do_read(0, 32'h8000_0030, d, resp, lat);
        chk("t3_rdata", d, 32'h5555_AAAA);

        // Out-of-range accesses and the last in-range word.
        do_read(0, 32'h7FFF_FFFC, d, resp, lat);
        chk("t4_lo_rresp", 32'(resp), 32'd2);
        chk("t4_lo_rdata", d, 32'd0);
        do_write(0, 32'h8000_1000, 32'h9999_9999, 4'hF, resp, lat);
        chk("t4_hi_bresp", 32'(resp), 32'd2);
        do_read(0, 32'h8000_1000, d, resp, lat);
        chk("t4_hi_rresp", 32'(resp), 32'd2);
        do_read(0, 32'h8000_0000, d, resp, lat);
        chk("t4_mem_unchanged", d, 32'h11BB_33DD);
        do_write(0, 32'h8000_0FFC, 32'h0BAD_CAFE, 4'hF, resp, lat);
        chk("t4_last_bresp", 32'(resp), 32'd0);
        do_read(0, 32'h8000_0FFC, d, resp, lat);
        chk("t4_last_rdata", d, 32'h0BAD_CAFE);

        // Low address bits do not select bytes.
        do_write(0, 32'h8000_0013, 32'h0102_0304, 4'hF, resp, lat);
        do_read(0, 32'h8000_0010, d, resp, lat);
        chk("t4_unaligned", d, 32'h0102_0304);

        // Read backpressure: response held five cycles.
        araddr[0] = 32'h8000_0010; arvalid[0] = 1'b1;
        tick();
        arvalid[0] = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) begin
            chk("t5_rvalid_hold", 32'(rvalid[0]), 32'd1);
            chk("t5_rdata_hold", rdata[0], 32'h0102_0304);
            chk("t5_arready_low", 32'(arready[0]), 32'd0);
            tick();
        end
        rready[0] = 1'b1;
        tick();
        rready[0] = 1'b0;
        chk("t5_rvalid_clr", 32'(rvalid[0]), 32'd0);
        chk("t5_arready_back", 32'(arready[0]), 32'd1);

        // Same-edge commit and read sample return the old word.
        do_write(0, 32'h8000_0020, 32'hA1A1_A1A1, 4'hF, resp, lat);
        awaddr[0] = 32'h8000_0020; wdata[0] = 32'hB2B2_B2B2; wstrb[0] = 4'hF;
        awvalid[0] = 1'b1; wvalid[0] = 1'b1;
        araddr[0] = 32'h8000_0020; arvalid[0] = 1'b1;
        tick();
        awvalid[0] = 1'b0; wvalid[0] = 1'b0; arvalid[0] = 1'b0;
        tick();
        chk("rbw_bvalid", 32'(bvalid[0]), 32'd1);
        chk("rbw_rvalid", 32'(rvalid[0]), 32'd1);
        chk("rbw_old_data", rdata[0], 32'hA1A1_A1A1);
        bready[0] = 1'b1; rready[0] = 1'b1;
        tick();
        bready[0] = 1'b0; rready[0] = 1'b0;
        do_read(0, 32'h8000_0020, d, resp, lat);
        chk("rbw_new_data", d, 32'hB2B2_B2B2);

        // DELAY=10 instance: latency, then reset during W_WAIT.
        do_write(1, 32'h8000_0040, 32'h1234_5678, 4'hF, resp, lat);
        chk("t6_wlat10", 32'(lat), 32'd10);
        chk("t6_bresp", 32'(resp), 32'd0);
        chk("t6_idle_awready", 32'(awready[1]), 32'd1);
        awaddr[1] = 32'h8000_0040; wdata[1] = 32'hCAFE_F00D; wstrb[1] = 4'hF;
        awvalid[1] = 1'b1; wvalid[1] = 1'b1;
        tick();
        awvalid[1] = 1'b0; wvalid[1] = 1'b0;
        repeat (5) tick();
        rst_n[1] = 1'b0;
        #1;
        chk("t6_rst_awready", 32'(awready[1]), 32'd0);
        chk("t6_rst_wready",  32'(wready[1]),  32'd0);
        chk("t6_rst_arready", 32'(arready[1]), 32'd0);
        chk("t6_rst_bvalid",  32'(bvalid[1]),  32'd0);
        chk("t6_rst_rvalid",  32'(rvalid[1]),  32'd0);
        chk("t6_rst_bresp",   32'(bresp[1]),   32'd0);
        repeat (2) tick();
        rst_n[1] = 1'b1;
        repeat (15) tick();
        chk("t6_no_late_bvalid", 32'(bvalid[1]), 32'd0);
        do_read(1, 32'h8000_0040, d, resp, lat);
        chk("t6_no_partial_write", d, 32'h1234_5678);
        chk("t6_rlat10", 32'(lat), 32'd10);
        chk("t6_rresp", 32'(resp), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/axi_lite_sram.md
# axi_lite_sram

AXI-lite slave memory that sits directly downstream of the load/store unit's memory interface. It consumes the LSU's AW/W/B and AR/R channels, stores data in an internal word array, and returns load data and write responses after a programmable latency. It is the behavioural data memory for simulation and FPGA bring-up, with the same channel names and widths as the LSU master ports.

## Interface
- `ADDR_BASE`, default 32'h8000_0000: byte address of word 0.
- `DEPTH_WORDS`, default 1024: number of 32-bit words; must be a power of two, at least 2.
- `DELAY`, default 1: fixed response latency in cycles, legal range 1..255.

Ports:
- `i_clk` in 1: clock. Everything is rising-edge.
- `i_rst_n` in 1: reset. One clock; reset is asynchronous and active-low.
- `awaddr` in 32, `awvalid` in 1, `awready` out 1: write address channel.
- `wdata` in 32, `wstrb` in 4, `wvalid` in 1, `wready` out 1: write data channel.
- `bresp` out 2, `bvalid` out 1, `bready` in 1: write response channel.
- `araddr` in 32, `arvalid` in 1, `arready` out 1: read address channel.
- `rdata` out 32, `rresp` out 2, `rvalid` out 1, `rready` in 1: read data channel.

## Operation
- **Independent FSMs.** The read and write paths run as two FSMs with no shared state apart from the memory array.
- **Address decode.**
  - In range: `ADDR_BASE <= addr < ADDR_BASE + 4*DEPTH_WORDS`.
  - Word index: `(addr - ADDR_BASE) >> 2`, truncated to log2(DEPTH_WORDS) bits.
  - `addr[1:0]` is ignored; byte lanes are selected by `wstrb` only.
- **Write FSM states:** W_IDLE, W_WAIT, W_RESP.
  - In W_IDLE, `awready` is high until AW is captured and `wready` is high until W is captured. AW and W may arrive in the same cycle or in either order.
  - Once both are captured, go to W_WAIT and load the latency counter.
  - When the counter expires, commit the write and go to W_RESP with `bvalid`=1.
    - Byte lane i is written only if `wstrb[i]`=1. `wstrb`=0 writes nothing and responds OKAY.
    - Out-of-range: no write, `bresp`=2'b10 (SLVERR). Otherwise `bresp`=2'b00.
  - In W_RESP, hold `bvalid`/`bresp` until `bvalid && bready`, then return to W_IDLE.
- **Read FSM states:** R_IDLE, R_WAIT, R_RESP.
  - In R_IDLE, `arready`=1. On `arvalid`, capture the address and go to R_WAIT, loading the counter.
  - When the counter expires, register `rdata` from the array and go to R_RESP with `rvalid`=1.
    - Out-of-range: `rdata`=0 and `rresp`=2'b10. Otherwise `rresp`=2'b00.
  - Hold `rdata`/`rresp`/`rvalid` stable until `rvalid && rready`, then return to R_IDLE.
- **Same-cycle read and write.** If a write commit and a read sample hit the same word in the same cycle, the read returns the old data (read-before-write).
- **Memory contents** are not reset and are undefined until written.

## Timing
- **Reset values (async assert):**
  - `awready`=`wready`=`arready`=0.
  - `bvalid`=`rvalid`=0, `bresp`=`rresp`=0, `rdata`=0.
  - Both FSMs in IDLE.
- **After reset:** the ready signals go high on the first rising edge after `i_rst_n` deasserts.
- **Reset mid-transaction:** the transaction is abandoned, with no partial write. A commit scheduled on the same edge as reset assertion is dropped.
- **Latency:** let cycle T be the handshake of the last of AW/W (or of AR).
  - `bvalid`/`rvalid` rise at edge T+D, where D is the current delay (D >= 1). With D=1, the response is visible the cycle after the handshake.
  - For writes, the array update is visible to a read sampling at T+D+1 or later.
- **Throughput:** ready outputs are low from capture until the response handshake completes, so each channel has at most one outstanding transaction.
- **Back-to-back:** a new request can be accepted no earlier than the cycle after the B/R handshake.
- **Counter:** 8 bits, counts down from D-1 to 0. In the `DELAY`=255 case, expiry is exactly 255 cycles after capture.
- **Ready without valid:** `bready`/`rready` asserted while the matching valid is low has no effect.

## Configuration
- **Macro:** `SRAM_RAND_DELAY_EN`.
- **Defined:**
  - An 8-bit Fibonacci LFSR (taps 8,6,5,4; seed 8'h5A; reset to the seed) advances every cycle.
  - Each time an FSM enters WAIT, D = `lfsr[3:0]` + 1, giving 1..16.
  - The read and write FSMs each sample the LFSR at their own entry.
  - `DELAY` is ignored.
- **Undefined:** D = `DELAY` for every transaction, and there is no LFSR logic.

## Test plan
1. **Full-word write then read.** Reset, `DELAY`=1. Write 32'hDEAD_BEEF to 32'h8000_0010 with `wstrb`=4'hF, then read the same address. Expect `bresp`=0 at T+1, `rdata`=32'hDEAD_BEEF, `rresp`=0.
2. **Byte-lane strobe.** Preload 32'h1122_3344 at 32'h8000_0000. Write 32'hAABB_CCDD with `wstrb`=4'b0101. Expect a later read to return 32'h11BB_33DD.
3. **Split AW/W.** Send AW at cycle 0 and W at cycle 3. Expect `awready` to drop at cycle 1, no response before W, and `bvalid` at cycle 3+D.
4. **Out-of-range.** Read 32'h7FFF_FFFC and write 32'h8000_1000 (DEPTH 1024). Expect `rresp`=`bresp`=2'b10, `rdata`=0, and memory unchanged.
5. **Backpressure.** Hold `rready`=0 for 5 cycles after `rvalid`. Expect `rdata` and `rvalid` stable throughout, with `arready` low until the handshake.
6. **Reset mid-write.** Assert `i_rst_n`=0 during W_WAIT (`DELAY`=10). Expect all outputs 0 immediately, and a later read of the target word shows no update.
